// File: rtl/prim_fifo_pkg.sv
// Shared pointer type and level arithmetic for the synchronous watermark FIFO.
package prim_fifo_pkg;

    localparam int PTR_IDX_MAX = 16;

    typedef struct packed {
        logic                   wrap;
        logic [PTR_IDX_MAX-1:0] idx;
    } fifo_ptr_t;

    // Index width; a single-entry FIFO still carries one (always zero) index bit.
    function automatic int ptrv_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int fifo_depth(input fifo_ptr_t wptr, input fifo_ptr_t rptr,
                                      input int depth);
        if ((wptr.wrap != rptr.wrap) && (wptr.idx == rptr.idx)) begin
            return depth;
        end
        if (wptr.wrap == rptr.wrap) begin
            return int'(wptr.idx) - int'(rptr.idx);
        end
        return depth - int'(rptr.idx) + int'(wptr.idx);
    endfunction

endpackage

// File: rtl/prim_fifo_ptr.sv
// FIFO pointer: index wraps Depth-1 -> 0 and toggles the wrap bit.
// Latency: registered, new value visible the cycle after inc_i/clr_i.
// Backpressure: none; the caller only pulses inc_i on an accepted handshake.
module prim_fifo_ptr
    import prim_fifo_pkg::*;
#(
    parameter int unsigned Depth = 8
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      clr_i,
    input  logic      inc_i,
    output fifo_ptr_t ptr_o
);

    localparam int PtrW = ptrv_w(Depth);

    logic            r_wrap;
    logic [PtrW-1:0] r_idx;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wrap <= 1'b0;
            r_idx  <= '0;
        end else if (clr_i) begin
            r_wrap <= 1'b0;
            r_idx  <= '0;
        end else if (inc_i) begin
            if (r_idx == PtrW'(Depth - 1)) begin
                r_idx  <= '0;
                r_wrap <= ~r_wrap;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    assign ptr_o.wrap = r_wrap;
    assign ptr_o.idx  = PTR_IDX_MAX'(r_idx);

endmodule

// File: rtl/prim_fifo_sync_wm.sv
// Sync FIFO with runtime almost-full/empty thresholds and a clearable high watermark.
// Latency: zero-cycle read of the head entry; with Pass=1 an empty FIFO forwards wdata_i.
// Backpressure: wready_o is purely ~full. Optional sticky err_o via PRIM_FIFO_SYNC_WM_ERR_EN.
module prim_fifo_sync_wm
    import prim_fifo_pkg::*;
#(
    parameter int unsigned Width             = 16,
    parameter int unsigned Depth             = 8,
    parameter bit          Pass              = 1'b1,
    parameter bit          OutputZeroIfEmpty = 1'b1,
    localparam int         DepthW            = $clog2(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clr_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    input  logic [Width-1:0]  wdata_i,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [Width-1:0]  rdata_o,
    output logic [DepthW-1:0] depth_o,
    input  logic [DepthW-1:0] af_thresh_i,
    input  logic [DepthW-1:0] ae_thresh_i,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    input  logic              wm_clr_i,
    output logic [DepthW-1:0] wm_o,
    output logic              err_o
);

    localparam int PtrW = ptrv_w(Depth);

    if (Depth < 1) begin : g_depth_chk
        $error("prim_fifo_sync_wm: Depth must be at least 1");
    end

    fifo_ptr_t         w_wptr;
    fifo_ptr_t         w_rptr;
    logic              w_full;
    logic              w_empty;
    logic              w_wr_en;
    logic              w_rd_en;
    logic [PtrW-1:0]   w_widx;
    logic [PtrW-1:0]   w_ridx;
    logic [Width-1:0]  w_head;
    logic [Width-1:0]  w_rdata_raw;
    logic [DepthW-1:0] w_depth_next;
    logic [DepthW-1:0] r_wm;
    logic [Width-1:0]  r_mem [Depth];

    prim_fifo_ptr #(.Depth(Depth)) u_wptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (clr_i),
        .inc_i  (w_wr_en),
        .ptr_o  (w_wptr)
    );

    prim_fifo_ptr #(.Depth(Depth)) u_rptr (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (clr_i),
        .inc_i  (w_rd_en),
        .ptr_o  (w_rptr)
    );

    assign w_full   = (w_wptr.idx == w_rptr.idx) && (w_wptr.wrap != w_rptr.wrap);
    assign w_empty  = (w_wptr == w_rptr);
    assign w_widx   = w_wptr.idx[PtrW-1:0];
    assign w_ridx   = w_rptr.idx[PtrW-1:0];

    assign wready_o = ~w_full;
    assign rvalid_o = ~w_empty | (Pass & wvalid_i);
    assign w_wr_en  = wvalid_i & ~w_full;
    assign w_rd_en  = rvalid_o & rready_i;

    always_ff @(posedge clk_i) begin
        if (w_wr_en && !clr_i) begin
            r_mem[w_widx] <= wdata_i;
        end
    end

    // When empty with Pass=1 the word being written is also the head.
    assign w_head      = r_mem[w_ridx];
    assign w_rdata_raw = (Pass && w_empty) ? wdata_i : w_head;
    assign rdata_o     = (OutputZeroIfEmpty && !rvalid_o) ? '0 : w_rdata_raw;

    assign depth_o        = DepthW'(fifo_depth(w_wptr, w_rptr, int'(Depth)));
    assign almost_full_o  = (depth_o >= af_thresh_i);
    assign almost_empty_o = (depth_o <= ae_thresh_i);

    assign w_depth_next = depth_o + DepthW'(w_wr_en) - DepthW'(w_rd_en);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wm <= '0;
        end else if (clr_i || wm_clr_i) begin
            r_wm <= '0;
        end else if (w_depth_next > r_wm) begin
            r_wm <= w_depth_next;
        end
    end

    assign wm_o = r_wm;

`ifdef PRIM_FIFO_SYNC_WM_ERR_EN
    logic             r_err;
    logic             r_stall;
    logic [Width-1:0] r_wdata_q;
    logic             w_err_evt;

    // A stalled writer must hold its data; a reader must not pull from nothing.
    assign w_err_evt = (r_stall & wvalid_i & w_full & (wdata_i != r_wdata_q))
                     | (rready_i & ~rvalid_o & ~Pass)
                     | (depth_o > DepthW'(Depth));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_err     <= 1'b0;
            r_stall   <= 1'b0;
            r_wdata_q <= '0;
        end else begin
            r_stall   <= wvalid_i & w_full;
            r_wdata_q <= wdata_i;
            if (w_err_evt) begin
                r_err <= 1'b1;
            end
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_prim_fifo_sync_wm.sv
// Directed bench: Width=8 Depth=5 instances with Pass=0 (main) and Pass=1 (pass-through).
module tb_prim_fifo_sync_wm;

`ifdef PRIM_FIFO_SYNC_WM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk_i = 1'b0;
    logic       rst_ni;

    logic       clr, wvalid, wready, rvalid, rready, af, ae, wm_clr, err;
    logic [7:0] wdata, rdata;
    logic [2:0] depth, af_th, ae_th, wm;

    logic       clr_p, wvalid_p, wready_p, rvalid_p, rready_p, af_p, ae_p, wm_clr_p, err_p;
    logic [7:0] wdata_p, rdata_p;
    logic [2:0] depth_p, wm_p;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk_i = ~clk_i;

    prim_fifo_sync_wm #(.Width(8), .Depth(5), .Pass(1'b0), .OutputZeroIfEmpty(1'b1)) u_dut0 (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clr_i          (clr),
        .wvalid_i       (wvalid),
        .wready_o       (wready),
        .wdata_i        (wdata),
        .rvalid_o       (rvalid),
        .rready_i       (rready),
        .rdata_o        (rdata),
        .depth_o        (depth),
        .af_thresh_i    (af_th),
        .ae_thresh_i    (ae_th),
        .almost_full_o  (af),
        .almost_empty_o (ae),
        .wm_clr_i       (wm_clr),
        .wm_o           (wm),
        .err_o          (err)
    );

    prim_fifo_sync_wm #(.Width(8), .Depth(5), .Pass(1'b1), .OutputZeroIfEmpty(1'b1)) u_dut1 (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .clr_i          (clr_p),
        .wvalid_i       (wvalid_p),
        .wready_o       (wready_p),
        .wdata_i        (wdata_p),
        .rvalid_o       (rvalid_p),
        .rready_i       (rready_p),
        .rdata_o        (rdata_p),
        .depth_o        (depth_p),
        .af_thresh_i    (3'd4),
        .ae_thresh_i    (3'd1),
        .almost_full_o  (af_p),
        .almost_empty_o (ae_p),
        .wm_clr_i       (wm_clr_p),
        .wm_o           (wm_p),
        .err_o          (err_p)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wr(input logic [7:0] d);
        wvalid = 1'b1;
        wdata  = d;
        step();
        wvalid = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] exp);
        rready = 1'b1;
        #1;
        check(tag, rdata, exp);
        step();
        rready = 1'b0;
    endtask

    initial begin
        rst_ni = 1'b0;
        clr = 1'b0; wvalid = 1'b0; rready = 1'b0; wm_clr = 1'b0; wdata = '0;
        af_th = 3'd4; ae_th = 3'd1;
        clr_p = 1'b0; wvalid_p = 1'b0; rready_p = 1'b0; wm_clr_p = 1'b0; wdata_p = '0;
        #1;
        check("rst_depth", depth, 0);
        check("rst_wready", wready, 1);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        check("rst_ae", ae, 1);
        check("rst_af", af, 0);
        check("rst_wm", wm, 0);
        check("rst_err", err, 0);
        check("rst_rvalid_p", rvalid_p, 0);
        af_th = 3'd0;
        #1;
        check("rst_af_th0", af, 1);
        af_th = 3'd4;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step();

        // Pass-through: word written into empty FIFO is read the same cycle.
        wvalid_p = 1'b1; wdata_p = 8'hA5; rready_p = 1'b1;
        #1;
        check("pass_rvalid", rvalid_p, 1);
        check("pass_rdata", rdata_p, 8'hA5);
        step();
        wvalid_p = 1'b0; rready_p = 1'b0;
        #1;
        check("pass_depth", depth_p, 0);
        check("pass_wm", wm_p, 0);

        // Fill 0x11..0x55 with no reads.
        for (int i = 0; i < 5; i++) begin
            wvalid = 1'b1;
            wdata  = 8'(8'h11 * (i + 1));
            #1;
            check("fill_wready", wready, 1);
            step();
            check("fill_depth", depth, i + 1);
            if (i == 2) check("af_at3", af, 0);
            if (i == 3) check("af_at4", af, 1);
        end
        wvalid = 1'b0;
        check("full_wready", wready, 0);
        check("full_depth", depth, 5);
        check("full_wm", wm, 5);
        check("full_ae", ae, 0);

        // Full with simultaneous read: write refused, read taken.
        wvalid = 1'b1; wdata = 8'h66; rready = 1'b1;
        #1;
        check("fullrw_rdata", rdata, 8'h11);
        check("fullrw_wready", wready, 0);
        step();
        wvalid = 1'b0; rready = 1'b0;
        check("fullrw_depth", depth, 4);
        check("fullrw_wready2", wready, 1);
        for (int i = 1; i < 5; i++) begin
            rd("drain_rdata", 8'(8'h11 * (i + 1)));
            check("drain_depth", depth, 4 - i);
            if (i == 2) check("ae_at2", ae, 0);
            if (i == 3) check("ae_at1", ae, 1);
        end
        check("empty_rvalid", rvalid, 0);
        check("empty_rdata", rdata, 0);

        // Wrap-around: write 3, read 3, write 5.
        wr(8'hA1); wr(8'hA2); wr(8'hA3);
        rd("wrap_a1", 8'hA1); rd("wrap_a2", 8'hA2); rd("wrap_a3", 8'hA3);
        for (int i = 0; i < 5; i++) wr(8'(8'hB1 + i));
        check("wrap_depth", depth, 5);
        check("wrap_wready", wready, 0);
        check("wrap_wptr_wrap", u_dut0.w_wptr.wrap, 0);
        check("wrap_rptr_wrap", u_dut0.w_rptr.wrap, 1);
        check("wrap_wptr_idx", u_dut0.w_wptr.idx, 3);
        af_th = 3'd7;
        #1;
        check("af_th7_full", af, 0);
        af_th = 3'd4;
        for (int i = 0; i < 5; i++) rd("wrap_rdata", 8'(8'hB1 + i));
        check("wrap_empty_depth", depth, 0);

        // Watermark: clear, fill 4, drain, clear again.
        wm_clr = 1'b1; step(); wm_clr = 1'b0;
        check("wm_clr0", wm, 0);
        for (int i = 0; i < 4; i++) wr(8'(8'hC1 + i));
        for (int i = 0; i < 4; i++) rd("wm_rdata", 8'(8'hC1 + i));
        check("wm_peak4", wm, 4);
        check("wm_depth0", depth, 0);
        wm_clr = 1'b1; step(); wm_clr = 1'b0;
        check("wm_clr1", wm, 0);
        wm_clr = 1'b1; wr(8'hE1); wm_clr = 1'b0;
        check("wm_clr_wins", wm, 0);
        check("wm_clr_depth", depth, 1);
        step();
        check("wm_recapture", wm, 1);
        wr(8'hE2);
        check("wm_at2", wm, 2);
        clr = 1'b1; wvalid = 1'b1; wdata = 8'hE3;
        step();
        clr = 1'b0; wvalid = 1'b0;
        check("flush_depth", depth, 0);
        check("flush_wm", wm, 0);
        check("flush_rvalid", rvalid, 0);

        // Asynchronous reset between clock edges.
        wr(8'hD1); wr(8'hD2); wr(8'hD3);
        check("pre_arst_depth", depth, 3);
        #2;
        rst_ni = 1'b0;
        #1;
        check("arst_depth", depth, 0);
        check("arst_wready", wready, 1);
        check("arst_rvalid", rvalid, 0);
        check("arst_rdata", rdata, 0);
        check("arst_wm", wm, 0);
        check("arst_err", err, 0);
        check("arst_ae", ae, 1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step();

        // Reading an empty FIFO with Pass=0 trips the sticky error when enabled.
        rready = 1'b1;
        step();
        rready = 1'b0;
        check("err_rd_empty", err, ERR_EN);
        step();
        check("err_sticky", err, ERR_EN);
        check("err_pass_inst", err_p, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
